// File: rtl/reg_ctrl_sequencer.sv
// rtl/reg_ctrl_sequencer.sv - command sequencer driving the datapath register ctrl/data
// Accepts CLEAR/LOAD/INCR/DECR commands and reports the final register value and wrap.
module reg_ctrl_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    input  logic                  abort,
    output logic [2:0]            reg_ctrl,
    output logic [DATA_WIDTH-1:0] reg_data,
    input  logic [DATA_WIDTH-1:0] reg_value,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  wrap
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_INCR  = 2'b10;
    localparam logic [1:0] OP_DECR  = 2'b11;

    localparam logic [2:0] CTRL_NONE = 3'd0;
    localparam logic [2:0] CTRL_CLR  = 3'd1;
    localparam logic [2:0] CTRL_LOAD = 3'd2;
    localparam logic [2:0] CTRL_INCR = 3'd3;
    localparam logic [2:0] CTRL_DECR = 3'd4;

    state_t                state_q, state_d;
    logic [2:0]            reg_ctrl_q, reg_ctrl_d;
    logic [DATA_WIDTH-1:0] reg_data_q, reg_data_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  wrap_q, wrap_d;
    logic [CNT_WIDTH-1:0]  step_q, step_d;
    logic [1:0]            op_q, op_d;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign reg_ctrl  = reg_ctrl_q;
    assign reg_data  = reg_data_q;
    assign done      = done_q;
    assign result    = result_q;
    assign wrap      = wrap_q;

    always_comb begin
        state_d    = state_q;
        reg_ctrl_d = reg_ctrl_q;
        reg_data_d = reg_data_q;
        done_d     = 1'b0;
        result_d   = result_q;
        wrap_d     = wrap_q;
        step_d     = step_q;
        op_d       = op_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    wrap_d = 1'b0;
                    case (cmd_op)
                        OP_CLEAR: begin
                            step_d     = CNT_WIDTH'(1);
                            reg_ctrl_d = CTRL_CLR;
                            state_d    = ST_EXEC;
                        end
                        OP_LOAD: begin
                            step_d     = CNT_WIDTH'(1);
                            reg_ctrl_d = CTRL_LOAD;
                            reg_data_d = cmd_data;
                            state_d    = ST_EXEC;
                        end
                        default: begin
                            // A zero-step INCR/DECR skips EXEC and leaves the register alone.
                            if (cmd_count == '0) begin
                                step_d     = '0;
                                reg_ctrl_d = CTRL_NONE;
                                state_d    = ST_DONE;
                            end else begin
                                step_d     = cmd_count;
                                reg_ctrl_d = (cmd_op == OP_INCR) ? CTRL_INCR : CTRL_DECR;
                                state_d    = ST_EXEC;
                            end
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                step_d = step_q - CNT_WIDTH'(1);
                // reg_value here is the value before this cycle's step lands.
                if ((op_q == OP_INCR && reg_value == {DATA_WIDTH{1'b1}}) ||
                    (op_q == OP_DECR && reg_value == '0)) begin
                    wrap_d = 1'b1;
                end
                if (step_q == CNT_WIDTH'(1) || (abort && op_q[1])) begin
                    step_d     = '0;
                    reg_ctrl_d = CTRL_NONE;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                result_d = reg_value;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                reg_ctrl_d = CTRL_NONE;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            reg_ctrl_q <= CTRL_NONE;
            reg_data_q <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            wrap_q     <= 1'b0;
            step_q     <= '0;
            op_q       <= OP_CLEAR;
        end else begin
            state_q    <= state_d;
            reg_ctrl_q <= reg_ctrl_d;
            reg_data_q <= reg_data_d;
            done_q     <= done_d;
            result_q   <= result_d;
            wrap_q     <= wrap_d;
            step_q     <= step_d;
            op_q       <= op_d;
        end
    end

endmodule

// File: doc/reg_ctrl_sequencer.md
# reg_ctrl_sequencer

Command sequencer that sits directly upstream of the datapath `register` block. It accepts one command at a time over a valid/ready handshake and drives the register's 3-bit `ctrl` code and `data_input`. Supported commands are CLEAR, LOAD, and multi-step INCREMENT or DECREMENT by a programmable count. It monitors the register's `data_output` and, once the command completes, reports the final value and a wrap flag.

## Interface
- `DATA_WIDTH`, default 8: width of the register data path.
- `CNT_WIDTH`, default 4: width of the step count; maximum is 2^CNT_WIDTH-1 steps.

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command; equal to (state == IDLE).
- `cmd_op`  in  2: 00 CLEAR, 01 LOAD, 10 INCR, 11 DECR.
- `cmd_data`  in  DATA_WIDTH: load value, used by LOAD only.
- `cmd_count`  in  CNT_WIDTH: step count, used by INCR/DECR only.
- `abort`  in  1: stops an INCR/DECR early.
- `reg_ctrl`  out  3: register control code; 0 NONE, 1 CLR, 2 LOAD, 3 INCR, 4 DECR.
- `reg_data`  out  DATA_WIDTH: drives the register `data_input`.
- `reg_value`  in  DATA_WIDTH: register `data_output`.
- `busy`  out  1: high in EXEC and DONE.
- `done`  out  1: one-cycle completion pulse.
- `result`  out  DATA_WIDTH: register value at completion; held until the next completion.
- `wrap`  out  1: the last command wrapped the register; valid with `done`, held until the next accept.

## Operation
- The FSM has three states: IDLE, EXEC, DONE. All outputs except `cmd_ready` and `busy` are registered.
- Reset values: state IDLE, `reg_ctrl`=0, `reg_data`=0, `done`=0, `result`=0, `wrap`=0, internal step counter 0. `cmd_ready`=1 during reset.
- Accept: when `cmd_valid` && `cmd_ready` at a rising edge, latch op, data and count, and clear `wrap`.
  - `reg_data` takes `cmd_data` on LOAD and holds its previous value for all other ops.
- IDLE→EXEC on accept in these cases:
  - CLEAR: steps = 1.
  - LOAD: steps = 1.
  - INCR/DECR with `cmd_count` ≥ 1: steps = `cmd_count`.
- IDLE→DONE directly for INCR/DECR with `cmd_count` = 0. `reg_ctrl` stays NONE and the register is untouched.
- EXEC: drive the op's code on `reg_ctrl` for exactly `steps` consecutive cycles, decrementing the step counter each edge. At the final step, EXEC→DONE.
- DONE:
  - Lasts one cycle with `reg_ctrl`=NONE.
  - At its closing edge: `result` ← `reg_value`, `done` ← 1, state → IDLE.
  - `done` clears after one cycle.
- Wrap detection is sampled every EXEC cycle:
  - INCR: if `reg_value` = all-ones, set `wrap`.
  - DECR: if `reg_value` = 0, set `wrap`.
  - `wrap` is sticky for the remainder of the command.
- Abort applies only in EXEC for INCR/DECR. If `abort`=1 at an EXEC edge:
  - The step issued in that cycle still takes effect.
  - The remaining steps are discarded and the state goes EXEC→DONE.
  - `abort` is ignored in IDLE, in DONE, and for CLEAR/LOAD.
- `cmd_op`, `cmd_data` and `cmd_count` are don't-care while `cmd_ready`=0.
- Asynchronous reset mid-operation: all registered outputs return to their reset values immediately, including `reg_ctrl` → NONE. The command in flight is lost and no `done` is generated.

## Timing
- Notation: handshake at edge E0; C_i is the cycle following edge E_(i-1)... concretely, C1 is the cycle after E0.
- EXEC occupies C1..CN with `reg_ctrl` active. The register updates at each edge E1..EN.
- C(N+1) is DONE, and `reg_value` is final in that cycle.
- `done`=1 and `result` are valid in C(N+2). `cmd_ready`=1 in the same cycle, so a new command can be accepted there: minimum spacing between accepts is N+2 edges.
- CLEAR and LOAD use N=1: `done` comes 3 cycles after accept.
- Count 0: DONE is C1 and `done` is in C2.
- `cmd_ready`=0 from C1 through C(N+1).

## Test plan
- LOAD 0x5A accepted at E0 → `reg_ctrl`=2 in C1 only, `reg_data`=0x5A, `done` in C3, `result`=0x5A, `wrap`=0.
- Register at 0xFE, INCR count=3 → `reg_ctrl`=3 for C1–C3, `done` in C5, `result`=0x01, `wrap`=1.
- DECR count=0 with register at 0x10 → `reg_ctrl` stays 0, `done` in C2, `result`=0x10, `wrap`=0.
- `cmd_valid` held high with CLEAR then INCR count=2 → `cmd_ready` low in C1–C2; the second command is accepted in C3 coincident with the first `done`; final `result`=0x02.
- Register at 0x20, INCR count=10, `abort` high in C4 → exactly 4 INCR cycles, `result`=0x24, `done` in C6.
- `rst` driven low in C2 of a DECR count=5 → `reg_ctrl`=0, `busy`=0, `cmd_ready`=1 immediately with no clock; no `done` after release.
